// File: rtl/mem_responder_if.sv
// Request/response handshake between a load/store initiator and mem_responder.
// The shared tristate data byte stays a plain port on the responder.
interface mem_responder_if;
   logic [15:0] memory_address_bus;
   logic        memory_enable;
   logic        memory_write_enable;
   logic        memory_ready;
   logic        memory_error;

   modport master (
      output memory_address_bus,
      output memory_enable,
      output memory_write_enable,
      input  memory_ready,
      input  memory_error
   );

   modport slave (
      input  memory_address_bus,
      input  memory_enable,
      input  memory_write_enable,
      output memory_ready,
      output memory_error
   );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states, out-of-range
// detection and a tristate data bus driven only when returning read data.
module mem_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk,
   input  logic            rst,
   inout  wire  [7:0]      memory_data_bus,
   mem_responder_if.slave  bus
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                 state_q;
   logic [3:0]             cnt_q;
   logic [15:0]            addr_q;
   logic                   we_q;
   logic [7:0]             wdata_q;
   logic [7:0]             rdata_q;
   logic                   ready_q;
   logic                   error_q;
   logic                   drive_q;
   logic                   in_range_s;
   logic                   wr_en_s;
   logic [ADDR_BITS-1:0]   idx_s;

   logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

   assign idx_s = addr_q[ADDR_BITS-1:0];

   // Any set bit above the implemented range makes the access out of range.
   generate
      if (ADDR_BITS < 16) begin : g_range
         assign in_range_s = (addr_q[15:ADDR_BITS] == '0);
      end else begin : g_full
         assign in_range_s = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'd0;
         we_q    <= 1'b0;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         error_q <= 1'b0;
         drive_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.memory_enable) begin
                  addr_q <= bus.memory_address_bus;
                  we_q   <= bus.memory_write_enable;
                  if (bus.memory_write_enable) begin
                     wdata_q <= memory_data_bus;
                  end
                  if (WAIT_STATES > 0) begin
                     cnt_q   <= WAIT_LOAD;
                     state_q <= WAIT;
                  end else begin
                     state_q <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (cnt_q <= 4'd1) begin
                  cnt_q   <= 4'd0;
                  state_q <= ACCESS;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ACCESS: begin
               // Outputs are set here so they are registered and valid throughout DONE.
               if (!we_q) begin
                  rdata_q <= in_range_s ? mem_q[idx_s] : 8'hFF;
               end
               ready_q <= 1'b1;
               error_q <= ~in_range_s;
               drive_q <= ~we_q;
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // An asynchronous reset pulls state_q out of ACCESS, which discards a pending write.
   assign wr_en_s = (state_q == ACCESS) && we_q && in_range_s && !rst;

   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[idx_s] <= wdata_q;
      end
   end

   assign memory_data_bus  = drive_q ? rdata_q : 8'hzz;
   assign bus.memory_ready = ready_q;
   assign bus.memory_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=1 main instance plus
// WAIT_STATES=0 and WAIT_STATES=15 instances for latency checks.
module tb_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_en;
   logic        req_we;
   logic [15:0] req_addr;
   logic        tb_drv;
   logic [7:0]  tb_data;

   int n_cmp;
   int n_mis;
   int hz_bad;
   int ready_stuck;

   wire [7:0] db_m;
   wire [7:0] db_0;
   wire [7:0] db_15;

   // Undriven main bus floats to 0xFF, making high-Z observable.
   pullup p_m (db_m);
   assign db_m = tb_drv ? tb_data : 8'hzz;

   mem_responder_if if_m ();
   mem_responder_if if_0 ();
   mem_responder_if if_15 ();

   assign if_m.memory_enable        = req_en;
   assign if_m.memory_write_enable  = req_we;
   assign if_m.memory_address_bus   = req_addr;
   assign if_0.memory_enable        = req_en;
   assign if_0.memory_write_enable  = req_we;
   assign if_0.memory_address_bus   = req_addr;
   assign if_15.memory_enable       = req_en;
   assign if_15.memory_write_enable = req_we;
   assign if_15.memory_address_bus  = req_addr;

   mem_responder #(.ADDR_BITS(12), .WAIT_STATES(1)) u_dut (
      .clk(clk), .rst(rst), .memory_data_bus(db_m), .bus(if_m.slave));
   mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .memory_data_bus(db_0), .bus(if_0.slave));
   mem_responder #(.ADDR_BITS(12), .WAIT_STATES(15)) u_ws15 (
      .clk(clk), .rst(rst), .memory_data_bus(db_15), .bus(if_15.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transaction on the main instance; inputs are disturbed right after acceptance.
   task automatic do_txn(input logic we, input logic [15:0] addr, input logic [7:0] data,
                         input logic [15:0] addr_after, output logic [7:0] rd,
                         output logic err, output int lat);
      int cyc;
      req_addr = addr;
      req_we   = we;
      req_en   = 1'b1;
      tb_drv   = we;
      tb_data  = data;
      @(posedge clk); #1;
      req_en   = 1'b0;
      req_addr = addr_after;
      req_we   = ~we;
      tb_data  = 8'h00;
      cyc      = 1;
      while (if_m.memory_ready !== 1'b1 && cyc < 40) begin
         if (!we && db_m !== 8'hff) hz_bad++;
         @(posedge clk); #1;
         cyc++;
      end
      rd  = db_m;
      err = if_m.memory_error;
      lat = (if_m.memory_ready === 1'b1) ? cyc + 1 : -1;
      tb_drv = 1'b0;
      req_we = 1'b0;
      @(posedge clk); #1;
      if (if_m.memory_ready !== 1'b0 || if_m.memory_error !== 1'b0) ready_stuck++;
   endtask

   initial begin
      logic [7:0] rd;
      logic       err;
      int         lat;
      int         f_m, f_0, f_15, w_m, w_0, w_15;
      logic [7:0] done_bus;
      int         first_r, second_r, n_pulse, bad_data;

      n_cmp = 0; n_mis = 0; hz_bad = 0; ready_stuck = 0;
      rst = 1'b1; req_en = 1'b0; req_we = 1'b0; req_addr = 16'h0000;
      tb_drv = 1'b0; tb_data = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", {15'd0, if_m.memory_ready}, 16'd0);
      check_eq("rst_error", {15'd0, if_m.memory_error}, 16'd0);
      check_eq("rst_bus_hiz", {8'd0, db_m}, 16'h00ff);
      rst = 1'b0;

      // Single-cycle read on all three builds; record DONE cycle index and pulse width.
      f_m = -1; f_0 = -1; f_15 = -1; w_m = 0; w_0 = 0; w_15 = 0; done_bus = 8'h5a;
      req_addr = 16'h0000; req_we = 1'b0; req_en = 1'b1;
      @(posedge clk); #1;
      req_en = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         if (if_m.memory_ready === 1'b1) begin
            if (f_m < 0) f_m = c;
            w_m++;
            done_bus = db_m;
         end else if (db_m !== 8'hff) begin
            hz_bad++;
         end
         if (if_0.memory_ready === 1'b1) begin
            if (f_0 < 0) f_0 = c;
            w_0++;
         end
         if (if_15.memory_ready === 1'b1) begin
            if (f_15 < 0) f_15 = c;
            w_15++;
         end
         @(posedge clk); #1;
      end
      check_eq("lat_ws1", 16'(f_m + 1), 16'd4);
      check_eq("lat_ws0", 16'(f_0 + 1), 16'd3);
      check_eq("lat_ws15", 16'(f_15 + 1), 16'd18);
      check_eq("width_ws1", 16'(w_m), 16'd1);
      check_eq("width_ws0", 16'(w_0), 16'd1);
      check_eq("width_ws15", 16'(w_15), 16'd1);
      check_eq("init_zero_rd", {8'd0, done_bus}, 16'h0000);

      do_txn(1'b1, 16'h0010, 8'h5a, 16'h0010, rd, err, lat);
      check_eq("wr5a_lat", 16'(lat), 16'd4);
      check_eq("wr5a_err", {15'd0, err}, 16'd0);
      do_txn(1'b0, 16'h0010, 8'h00, 16'h0010, rd, err, lat);
      check_eq("rd10_data", {8'd0, rd}, 16'h005a);
      check_eq("rd10_lat", 16'(lat), 16'd4);
      check_eq("rd10_err", {15'd0, err}, 16'd0);

      do_txn(1'b1, 16'h0000, 8'h9c, 16'h0000, rd, err, lat);
      do_txn(1'b1, 16'h1000, 8'h33, 16'h1000, rd, err, lat);
      check_eq("wr_oor_err", {15'd0, err}, 16'd1);
      check_eq("wr_oor_lat", 16'(lat), 16'd4);
      do_txn(1'b0, 16'h0000, 8'h00, 16'h0000, rd, err, lat);
      check_eq("rd0_no_alias", {8'd0, rd}, 16'h009c);
      check_eq("rd0_err", {15'd0, err}, 16'd0);
      do_txn(1'b0, 16'h1000, 8'h00, 16'h1000, rd, err, lat);
      check_eq("rd_oor_data", {8'd0, rd}, 16'h00ff);
      check_eq("rd_oor_err", {15'd0, err}, 16'd1);

      do_txn(1'b1, 16'h0fff, 8'ha5, 16'h0fff, rd, err, lat);
      do_txn(1'b0, 16'h0fff, 8'h00, 16'h0fff, rd, err, lat);
      check_eq("rd_top_data", {8'd0, rd}, 16'h00a5);

      // Data and address change right after acceptance must not reach the array.
      do_txn(1'b1, 16'h0020, 8'hc3, 16'h0021, rd, err, lat);
      do_txn(1'b0, 16'h0020, 8'h00, 16'h0000, rd, err, lat);
      check_eq("rd20_latched", {8'd0, rd}, 16'h00c3);
      do_txn(1'b0, 16'h0021, 8'h00, 16'h0021, rd, err, lat);
      check_eq("rd21_untouched", {8'd0, rd}, 16'h0000);

      do_txn(1'b1, 16'h0030, 8'h11, 16'h0030, rd, err, lat);
      req_addr = 16'h0030; req_we = 1'b1; req_en = 1'b1; tb_drv = 1'b1; tb_data = 8'h77;
      @(posedge clk); #1;
      req_en = 1'b0; tb_drv = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rst_wait_ready", {15'd0, if_m.memory_ready}, 16'd0);
      check_eq("rst_wait_bus", {8'd0, db_m}, 16'h00ff);
      @(posedge clk); #1;
      rst = 1'b0;
      do_txn(1'b0, 16'h0030, 8'h00, 16'h0030, rd, err, lat);
      check_eq("rd30_discarded", {8'd0, rd}, 16'h0011);
      check_eq("rd30_first_edge", 16'(lat), 16'd4);

      // Reset landing in DONE of an out-of-range read clears every output at once.
      req_addr = 16'h1000; req_we = 1'b0; req_en = 1'b1;
      @(posedge clk); #1;
      req_en = 1'b0;
      for (int c = 0; c < 10 && if_m.memory_ready !== 1'b1; c++) begin
         @(posedge clk); #1;
      end
      check_eq("pre_rst_done", {15'd0, if_m.memory_error}, 16'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_done_ready", {15'd0, if_m.memory_ready}, 16'd0);
      check_eq("rst_done_error", {15'd0, if_m.memory_error}, 16'd0);
      check_eq("rst_done_bus", {8'd0, db_m}, 16'h00ff);
      @(posedge clk); #1;
      rst = 1'b0;

      // Enable held high: back-to-back reads complete every four cycles.
      first_r = -1; second_r = -1; n_pulse = 0; bad_data = 0;
      req_addr = 16'h0010; req_we = 1'b0; req_en = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 12; c++) begin
         if (if_m.memory_ready === 1'b1) begin
            n_pulse++;
            if (first_r < 0) first_r = c;
            else if (second_r < 0) second_r = c;
            if (db_m !== 8'h5a) bad_data++;
         end else if (db_m !== 8'hff) begin
            hz_bad++;
         end
         @(posedge clk); #1;
      end
      req_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("hold_pulses", 16'(n_pulse), 16'd3);
      check_eq("hold_first", 16'(first_r), 16'd3);
      check_eq("hold_second", 16'(second_r), 16'd7);
      check_eq("hold_data", 16'(bad_data), 16'd0);
      check_eq("bus_hiz_nondone", 16'(hz_bad), 16'd0);
      check_eq("ready_one_cycle", 16'(ready_stuck), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning implemented byte-array depth is 2^ADDR_BITS (legal 1..16).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the number of inserted wait cycles per access (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port memory_data_bus  inout  8  shared byte data bus; driven by this block only when returning read data, else high-Z.
REQ-006 SHALL have port memory_address_bus  input  16  byte address from the load/store initiator.
REQ-007 SHALL have port memory_enable  input  1  request strobe from the initiator.
REQ-008 SHALL have port memory_write_enable  input  1  1 = write request, 0 = read request; qualified by memory_enable.
REQ-009 SHALL have port memory_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port memory_error  output  1  one-cycle pulse, coincident with memory_ready, flagging an out-of-range access.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACCESS, DONE.
REQ-012 IDLE: on a rising edge with memory_enable=1, SHALL latch address, memory_write_enable and (for writes) memory_data_bus, then go to WAIT if WAIT_STATES>0, else ACCESS; memory_enable=0 stays IDLE.
REQ-013 WAIT: SHALL load a 4-bit counter with WAIT_STATES on entry, decrement each cycle, and go to ACCESS in the cycle the counter reaches 1 (exactly WAIT_STATES cycles spent in WAIT).
REQ-014 ACCESS: write SHALL store the latched byte at the latched address; read SHALL load the addressed byte into an internal read-data register; always go to DONE.
REQ-015 DONE: SHALL assert memory_ready for exactly one cycle, then return unconditionally to IDLE.
REQ-016 Latency SHALL be WAIT_STATES+3 cycles from the accepting edge in IDLE to the DONE cycle, inclusive of IDLE; back-to-back requests are accepted only from IDLE.
REQ-017 memory_data_bus SHALL be driven with the read-data register only while state=DONE and the latched request is a read; high-Z in all other states.
REQ-018 Out of range: any of latched address[15:ADDR_BITS] nonzero (none when ADDR_BITS=16) SHALL suppress the write, return 0xFF on read, and assert memory_error in DONE.
REQ-019 In-range addressing SHALL use latched address[ADDR_BITS-1:0]; no wrap or aliasing of higher bits.
REQ-020 Changes on memory_enable, memory_write_enable, memory_address_bus or memory_data_bus after acceptance SHALL NOT affect the in-flight transaction; deasserting memory_enable mid-transaction does not abort it.
REQ-021 memory_ready and memory_error SHALL be registered outputs (no combinational path from inputs).
REQ-022 Array contents SHALL initialise to 0x00 at simulation start.

Reset
REQ-023 On rst=1, SHALL asynchronously force state IDLE, memory_ready=0, memory_error=0, wait counter 0, read-data register 0x00, memory_data_bus high-Z.
REQ-024 Reset SHALL NOT clear array contents; a write in WAIT or ACCESS when reset asserts is discarded (array unchanged at that address).
REQ-025 After rst deasserts, a request SHALL be accepted on the first rising edge with memory_enable=1.

Verification
REQ-026 Write 0x5A to 0x0010, then read 0x0010 (WAIT_STATES=1) -> read returns 0x5A on bus in DONE; memory_ready pulses 4 cycles after each accepting edge (IDLE..DONE inclusive).
REQ-027 WAIT_STATES=0 and WAIT_STATES=15 builds, one read each -> DONE reached after 3 and 18 cycles respectively; memory_ready width exactly 1 cycle.
REQ-028 Write 0x33 to 0x1000 (ADDR_BITS=12) -> memory_error=1 with memory_ready; subsequent read of 0x0000 returns prior value; read of 0x1000 returns 0xFF with memory_error=1.
REQ-029 Accept write of 0xC3 to 0x0020, change memory_data_bus to 0x00 and drop memory_enable next cycle -> 0xC3 stored; read of 0x0020 returns 0xC3.
REQ-030 Assert rst during WAIT of a write of 0x77 to 0x0030 previously holding 0x11 -> outputs reset immediately, bus high-Z; later read of 0x0030 returns 0x11.
REQ-031 Read with memory_enable held high continuously -> bus high-Z in every non-DONE cycle; a second transaction accepted in the IDLE cycle following DONE.
